// File: rtl/spi_flash_sequencer.sv
// -----------------------------------------------------------------------------
// spi_flash_sequencer
//   Shares the SPI transfer engine between two requesters (A = CPU command
//   port, B = boot/prefetch loader). For each granted request it writes
//   opcode + 24-bit address into the TX buffer, runs a 4-byte write transfer,
//   then a read transfer of the requested length, and releases chip select.
//
// Ports
//   FastClk, Reset            clock, synchronous active-high reset
//   ReqX/ReqXOpcode/Addr/Len  request + parameters from requester A / B
//   GrantX, DoneX, Error      ownership, one-cycle completion, start-failure flag
//   EngTxWrite/Addr/Data      TX buffer write port of the engine
//   EngLen, EngMode, EngCs    engine transfer setup and flash chip select
//   EngStart, EngBusy         engine start pulse / busy status
// -----------------------------------------------------------------------------
module spi_flash_sequencer #(
   parameter int START_TIMEOUT = 15
) (
   input  logic        FastClk,
   input  logic        Reset,
   input  logic        ReqA,
   input  logic [7:0]  ReqAOpcode,
   input  logic [23:0] ReqAAddr,
   input  logic [8:0]  ReqALen,
   input  logic        ReqB,
   input  logic [7:0]  ReqBOpcode,
   input  logic [23:0] ReqBAddr,
   input  logic [8:0]  ReqBLen,
   output logic        GrantA,
   output logic        GrantB,
   output logic        DoneA,
   output logic        DoneB,
   output logic        Error,
   output logic        EngTxWrite,
   output logic [8:0]  EngTxAddr,
   output logic [7:0]  EngTxData,
   output logic [8:0]  EngLen,
   output logic [1:0]  EngMode,
   output logic        EngCs,
   output logic        EngStart,
   input  logic        EngBusy
);

   typedef enum logic [2:0] {
      IDLE, LOAD_TX, CMD_START, CMD_WAIT, DATA_START, DATA_WAIT, RELEASE
   } state_t;

   localparam logic [3:0] TMO_LAST = 4'(START_TIMEOUT - 1);

   state_t      r_state;
   logic        r_last_b;   // LastServed: 1 = B
   logic        r_sel_b;    // current owner: 1 = B
   logic [7:0]  r_op;
   logic [23:0] r_addr;
   logic [8:0]  r_len;
   logic [1:0]  r_idx;      // next TX byte to present
   logic [3:0]  r_cnt;      // start-timeout counter, saturating
   logic        r_seen;     // EngBusy observed since the last start

   logic        w_pick_b;
   logic        w_wait;
   logic        w_tmo;
   logic        w_fall;
   logic [7:0]  w_tx_byte;

   // B wins if it is alone, or if both ask and A was served last
   assign w_pick_b = ReqB && (!ReqA || !r_last_b);
   assign w_wait   = (r_state == CMD_WAIT) || (r_state == DATA_WAIT);
   assign w_tmo    = w_wait && !r_seen && !EngBusy && (r_cnt == TMO_LAST);
   assign w_fall   = w_wait && r_seen && !EngBusy;

   always_comb begin
      w_tx_byte = r_addr[7:0];
      case (r_idx)
         2'd1:    w_tx_byte = r_addr[23:16];
         2'd2:    w_tx_byte = r_addr[15:8];
         default: w_tx_byte = r_addr[7:0];
      endcase
   end

   // Outputs are registered: each transition loads the values the next
   // state must present.
   always_ff @(posedge FastClk) begin
      if (Reset) begin
         r_state    <= IDLE;
         r_last_b   <= 1'b1;
         r_sel_b    <= 1'b0;
         r_op       <= '0;
         r_addr     <= '0;
         r_len      <= '0;
         r_idx      <= '0;
         r_cnt      <= '0;
         r_seen     <= 1'b0;
         GrantA     <= 1'b0;
         GrantB     <= 1'b0;
         DoneA      <= 1'b0;
         DoneB      <= 1'b0;
         Error      <= 1'b0;
         EngTxWrite <= 1'b0;
         EngTxAddr  <= '0;
         EngTxData  <= '0;
         EngLen     <= '0;
         EngMode    <= '0;
         EngCs      <= 1'b0;
         EngStart   <= 1'b0;
      end else begin
         EngStart   <= 1'b0;
         EngTxWrite <= 1'b0;
         DoneA      <= 1'b0;
         DoneB      <= 1'b0;
         Error      <= 1'b0;

         case (r_state)
            IDLE: begin
               if (ReqA || ReqB) begin
                  r_sel_b    <= w_pick_b;
                  r_op       <= w_pick_b ? ReqBOpcode : ReqAOpcode;
                  r_addr     <= w_pick_b ? ReqBAddr   : ReqAAddr;
                  r_len      <= w_pick_b ? ReqBLen    : ReqALen;
                  GrantA     <= !w_pick_b;
                  GrantB     <= w_pick_b;
                  EngTxWrite <= 1'b1;
                  EngTxAddr  <= 9'd0;
                  EngTxData  <= w_pick_b ? ReqBOpcode : ReqAOpcode;
                  r_idx      <= 2'd1;
                  r_state    <= LOAD_TX;
               end
            end
            LOAD_TX: begin
               if (r_idx == 2'd0) begin
                  // all four bytes written (index wrapped)
                  EngCs    <= 1'b1;
                  EngMode  <= 2'd0;
                  EngLen   <= 9'd3;
                  EngStart <= 1'b1;
                  r_state  <= CMD_START;
               end else begin
                  EngTxWrite <= 1'b1;
                  EngTxAddr  <= {7'd0, r_idx};
                  EngTxData  <= w_tx_byte;
                  r_idx      <= r_idx + 2'd1;
               end
            end
            CMD_START, DATA_START: begin
               r_cnt   <= '0;
               r_seen  <= 1'b0;
               r_state <= (r_state == CMD_START) ? CMD_WAIT : DATA_WAIT;
            end
            CMD_WAIT, DATA_WAIT: begin
               if (!r_seen) begin
                  if (EngBusy)                r_seen <= 1'b1;
                  else if (r_cnt != TMO_LAST) r_cnt  <= r_cnt + 4'd1;
               end
            end
            RELEASE: begin
               GrantA   <= 1'b0;
               GrantB   <= 1'b0;
               r_last_b <= r_sel_b;
               r_state  <= IDLE;
            end
            default: r_state <= IDLE;
         endcase

         // command phase finished: launch the data read, CS stays asserted
         if (w_fall && r_state == CMD_WAIT) begin
            EngMode  <= 2'd1;
            EngLen   <= r_len;
            EngStart <= 1'b1;
            r_state  <= DATA_START;
         end

         // normal completion or engine never started
         if (w_tmo || (w_fall && r_state == DATA_WAIT)) begin
            EngCs   <= 1'b0;
            DoneA   <= !r_sel_b;
            DoneB   <= r_sel_b;
            Error   <= w_tmo;
            r_state <= RELEASE;
         end
      end
   end

endmodule
